// File: rtl/pipe_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pipe_frame_arbiter
// Brief    : Round-robin, frame-locked arbiter that shares one fixed-latency
//            data_pipeline between NUM_REQ byte-stream sources. One source
//            owns the pipeline input for a whole frame. A {valid,last,id} tag
//            travels alongside the external pipeline so that each result beat
//            leaves tagged with its source.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_frame_arbiter #(
    parameter int  NUM_REQ    = 2,
    parameter int  DATA_W     = 8,
    parameter int  PIPE_DEPTH = 2,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]         pipe_data_o,
    input  logic [DATA_W-1:0]         pipe_data_i,
    output logic                      rsp_valid_o,
    output logic                      rsp_last_o,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [DATA_W-1:0]         rsp_data_o
);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_locked = 1'b1;
    localparam int         c_tag_w     = ID_W + 2;

    logic [0:0]         r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_owner;

    logic [ID_W:0]      w_scan;
    logic [ID_W-1:0]    w_sel;
    logic               w_found;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_gnt_any;
    logic [ID_W-1:0]    w_rr_next;
    logic               w_xfer;
    logic               w_xfer_last;
    logic [DATA_W-1:0]  w_xfer_data;
    logic [c_tag_w-1:0] w_tag_in;
    logic [c_tag_w-1:0] w_tag_out;

    // Round-robin scan from rr_ptr; the smallest offset holding a valid wins
    always_comb begin
        w_scan  = '0;
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_scan = {1'b0, r_rr_ptr} + (ID_W + 1)'(k);
            if (w_scan >= (ID_W + 1)'(NUM_REQ)) begin
                w_scan = w_scan - (ID_W + 1)'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if ((w_scan == (ID_W + 1)'(j)) && req_valid_i[j]) begin
                    w_sel   = ID_W'(j);
                    w_found = 1'b1;
                end
            end
        end
    end

    // Grant the lock owner, or the scan winner when idle; reset blocks all grants
    always_comb begin
        w_gnt_idx   = (r_state == c_st_locked) ? r_owner : w_sel;
        w_gnt_any   = (r_state == c_st_locked) || w_found;
        req_ready_o = '0;
        w_xfer      = 1'b0;
        w_xfer_last = 1'b0;
        w_xfer_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!rst && w_gnt_any && (w_gnt_idx == ID_W'(j))) begin
                req_ready_o[j] = 1'b1;
                if (req_valid_i[j]) begin
                    w_xfer      = 1'b1;
                    w_xfer_last = req_last_i[j];
                    w_xfer_data = req_data_i[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign w_rr_next   = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : (w_gnt_idx + ID_W'(1));
    assign pipe_data_o = w_xfer_data;

    // Frame lock: a non-last beat locks the source, a last beat releases and advances rr_ptr
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_rr_ptr <= '0;
            r_owner  <= '0;
        end else if (w_xfer) begin
            if (w_xfer_last) begin
                r_state  <= c_st_idle;
                r_rr_ptr <= w_rr_next;
            end else begin
                r_state  <= c_st_locked;
                r_owner  <= w_gnt_idx;
            end
        end
    end

    assign w_tag_in = {w_xfer, w_xfer_last, w_gnt_idx};

    generate
        if (PIPE_DEPTH == 0) begin : g_tag_bypass
            assign w_tag_out = w_tag_in;
        end else begin : g_tag_pipe
            logic [c_tag_w-1:0] r_tag [PIPE_DEPTH];

            // Tag shift register matching the external pipeline latency; reset kills in-flight beats
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DEPTH; i++) begin
                        r_tag[i] <= '0;
                    end
                end else begin
                    r_tag[0] <= w_tag_in;
                    for (int i = 1; i < PIPE_DEPTH; i++) begin
                        r_tag[i] <= r_tag[i-1];
                    end
                end
            end

            assign w_tag_out = r_tag[PIPE_DEPTH-1];
        end
    endgenerate

    assign rsp_valid_o = w_tag_out[c_tag_w-1];
    assign rsp_last_o  = rsp_valid_o & w_tag_out[c_tag_w-2];
    assign rsp_id_o    = rsp_valid_o ? w_tag_out[ID_W-1:0] : '0;
    assign rsp_data_o  = rsp_valid_o ? pipe_data_i : '0;

    a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready_o));

    generate
        if (PIPE_DEPTH == 0) begin : g_chk_comb
            a_rsp_hist: assert property (@(posedge clk) rsp_valid_o == w_xfer);
        end else begin : g_chk_hist
            logic [4:0] r_rst_age;

            // Cycles since reset, saturating once the tag pipe holds only post-reset history
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rst_age <= '0;
                end else if (r_rst_age < 5'(PIPE_DEPTH)) begin
                    r_rst_age <= r_rst_age + 5'd1;
                end
            end

            a_rsp_hist: assert property (@(posedge clk)
                (r_rst_age == 5'(PIPE_DEPTH)) |-> (rsp_valid_o == $past(w_xfer, PIPE_DEPTH)));
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_frame_arbiter
// Brief    : Directed self-checking bench for pipe_frame_arbiter. Three
//            instances: A (2 sources, depth 2), B (3 sources, depth 2) and
//            C (2 sources, depth 0). A and B sit behind a 2-stage model of the
//            external data_pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_frame_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: 2 sources, depth 2
    logic [1:0]  a_valid, a_last, a_ready;
    logic [15:0] a_data;
    logic [7:0]  a_pipe_out, a_pipe_in, a_p0, a_p1;
    logic        a_rsp_valid, a_rsp_last;
    logic [0:0]  a_rsp_id;
    logic [7:0]  a_rsp_data;

    pipe_frame_arbiter #(.NUM_REQ(2), .DATA_W(8), .PIPE_DEPTH(2)) u_a (
        .clk(clk), .rst(rst),
        .req_valid_i(a_valid), .req_last_i(a_last), .req_data_i(a_data),
        .req_ready_o(a_ready), .pipe_data_o(a_pipe_out), .pipe_data_i(a_pipe_in),
        .rsp_valid_o(a_rsp_valid), .rsp_last_o(a_rsp_last),
        .rsp_id_o(a_rsp_id), .rsp_data_o(a_rsp_data)
    );

    always_ff @(posedge clk) begin
        a_p0 <= a_pipe_out;
        a_p1 <= a_p0;
    end
    assign a_pipe_in = a_p1;

    // Instance B: 3 sources, depth 2
    logic [2:0]  b_valid, b_last, b_ready;
    logic [23:0] b_data;
    logic [7:0]  b_pipe_out, b_pipe_in, b_p0, b_p1;
    logic        b_rsp_valid, b_rsp_last;
    logic [1:0]  b_rsp_id;
    logic [7:0]  b_rsp_data;

    pipe_frame_arbiter #(.NUM_REQ(3), .DATA_W(8), .PIPE_DEPTH(2)) u_b (
        .clk(clk), .rst(rst),
        .req_valid_i(b_valid), .req_last_i(b_last), .req_data_i(b_data),
        .req_ready_o(b_ready), .pipe_data_o(b_pipe_out), .pipe_data_i(b_pipe_in),
        .rsp_valid_o(b_rsp_valid), .rsp_last_o(b_rsp_last),
        .rsp_id_o(b_rsp_id), .rsp_data_o(b_rsp_data)
    );

    always_ff @(posedge clk) begin
        b_p0 <= b_pipe_out;
        b_p1 <= b_p0;
    end
    assign b_pipe_in = b_p1;

    // Instance C: 2 sources, depth 0 (pipeline is a wire)
    logic [1:0]  c_valid, c_last, c_ready;
    logic [15:0] c_data;
    logic [7:0]  c_pipe_out;
    logic        c_rsp_valid, c_rsp_last;
    logic [0:0]  c_rsp_id;
    logic [7:0]  c_rsp_data;

    pipe_frame_arbiter #(.NUM_REQ(2), .DATA_W(8), .PIPE_DEPTH(0)) u_c (
        .clk(clk), .rst(rst),
        .req_valid_i(c_valid), .req_last_i(c_last), .req_data_i(c_data),
        .req_ready_o(c_ready), .pipe_data_o(c_pipe_out), .pipe_data_i(c_pipe_out),
        .rsp_valid_o(c_rsp_valid), .rsp_last_o(c_rsp_last),
        .rsp_id_o(c_rsp_id), .rsp_data_o(c_rsp_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_valid = '0; a_last = '0; a_data = '0;
        b_valid = '0; b_last = '0; b_data = '0;
        c_valid = '0; c_last = '0; c_data = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid = 2'b11; a_last = 2'b11; a_data = 16'hFFFF;
        b_valid = 3'b111; b_last = 3'b111; b_data = 24'hFFFFFF;
        c_valid = 2'b11; c_last = 2'b11; c_data = 16'hFFFF;
        #1;
        n_tests++;
        if (a_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready_a: got %b want 00", a_ready); end
        n_tests++;
        if (b_ready !== 3'b000) begin n_fail++; $display("FAIL rst_ready_b: got %b want 000", b_ready); end
        n_tests++;
        if (c_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready_c: got %b want 00", c_ready); end
        n_tests++;
        if (a_pipe_out !== 8'h00) begin n_fail++; $display("FAIL rst_pipe_a: got %h want 00", a_pipe_out); end
        n_tests++;
        if ({c_rsp_valid, c_rsp_last, c_rsp_id, c_rsp_data} !== 11'h000) begin
            n_fail++; $display("FAIL rst_rsp_c: got %b want 0", c_rsp_valid);
        end
        repeat (2) tick();
        clear_inputs();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_tests++;
            if ({a_rsp_valid, a_rsp_last, a_rsp_id, a_rsp_data} !== 11'h000) begin
                n_fail++; $display("FAIL post_rst_rsp_a cyc %0d: got %b want 0", k, a_rsp_valid);
            end
            n_tests++;
            if ({b_rsp_valid, b_rsp_last, b_rsp_id, b_rsp_data} !== 12'h000) begin
                n_fail++; $display("FAIL post_rst_rsp_b cyc %0d: got %b want 0", k, b_rsp_valid);
            end
            tick();
        end
    endtask

    task automatic test_single_frame();
        logic        vld  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        lst  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0]  dat  [6] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
        logic [1:0]  e_rdy[6] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
        logic [7:0]  e_pip[6] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
        logic [10:0] e_rsp[6] = '{11'h000, 11'h000, 11'h411, 11'h422, 11'h633, 11'h000};
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            a_valid = {1'b0, vld[k]};
            a_last  = {1'b0, lst[k]};
            a_data  = {8'h00, dat[k]};
            #1;
            n_tests++;
            if (a_ready !== e_rdy[k]) begin n_fail++; $display("FAIL frame_ready cyc %0d: got %b want %b", k, a_ready, e_rdy[k]); end
            n_tests++;
            if (a_pipe_out !== e_pip[k]) begin n_fail++; $display("FAIL frame_pipe cyc %0d: got %h want %h", k, a_pipe_out, e_pip[k]); end
            n_tests++;
            if ({a_rsp_valid, a_rsp_last, a_rsp_id, a_rsp_data} !== e_rsp[k]) begin
                n_fail++; $display("FAIL frame_rsp cyc %0d: got %h want %h", k, {a_rsp_valid, a_rsp_last, a_rsp_id, a_rsp_data}, e_rsp[k]);
            end
            tick();
        end
    endtask

    task automatic test_alternate();
        logic [1:0]  e_rdy[8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00};
        logic [10:0] e_rsp[8] = '{11'h000, 11'h000, 11'h4A0, 11'h6A1, 11'h5B0, 11'h7B1, 11'h4A2, 11'h6A3};
        logic [7:0]  cnt0;
        logic [7:0]  cnt1;
        cnt0 = 8'd0;
        cnt1 = 8'd0;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            a_valid = (k < 6) ? 2'b11 : 2'b00;
            a_last  = {cnt1[0], cnt0[0]};
            a_data  = {8'hB0 + cnt1, 8'hA0 + cnt0};
            #1;
            n_tests++;
            if (a_ready !== e_rdy[k]) begin n_fail++; $display("FAIL alt_ready cyc %0d: got %b want %b", k, a_ready, e_rdy[k]); end
            n_tests++;
            if ({a_rsp_valid, a_rsp_last, a_rsp_id, a_rsp_data} !== e_rsp[k]) begin
                n_fail++; $display("FAIL alt_rsp cyc %0d: got %h want %h", k, {a_rsp_valid, a_rsp_last, a_rsp_id, a_rsp_data}, e_rsp[k]);
            end
            if (e_rdy[k][0]) cnt0 = cnt0 + 8'd1;
            if (e_rdy[k][1]) cnt1 = cnt1 + 8'd1;
            tick();
        end
    endtask

    task automatic test_stall_lock();
        logic [1:0]  vld  [8] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b00, 2'b00};
        logic [1:0]  e_rdy[8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00};
        logic [10:0] e_rsp[8] = '{11'h000, 11'h000, 11'h4C0, 11'h000, 11'h000, 11'h000, 11'h6C1, 11'h7D0};
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            a_valid = vld[k];
            a_last  = {1'b1, (k == 4) ? 1'b1 : 1'b0};
            a_data  = {8'hD0, (k == 0) ? 8'hC0 : 8'hC1};
            #1;
            n_tests++;
            if (a_ready !== e_rdy[k]) begin n_fail++; $display("FAIL stall_ready cyc %0d: got %b want %b", k, a_ready, e_rdy[k]); end
            n_tests++;
            if ({a_rsp_valid, a_rsp_last, a_rsp_id, a_rsp_data} !== e_rsp[k]) begin
                n_fail++; $display("FAIL stall_rsp cyc %0d: got %h want %h", k, {a_rsp_valid, a_rsp_last, a_rsp_id, a_rsp_data}, e_rsp[k]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  vld  [7] = '{3'b001, 3'b110, 3'b110, 3'b110, 3'b110, 3'b000, 3'b000};
        logic [2:0]  e_rdy[7] = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b100, 3'b000, 3'b000};
        logic [7:0]  e_pip[7] = '{8'h50, 8'h11, 8'h22, 8'h13, 8'h24, 8'h00, 8'h00};
        logic [11:0] e_rsp[7] = '{12'h000, 12'h000, 12'hC50, 12'hD11, 12'hE22, 12'hD13, 12'hE24};
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            b_valid = vld[k];
            b_last  = 3'b111;
            b_data  = {8'h20 + 8'(k), 8'h10 + 8'(k), 8'h50};
            #1;
            n_tests++;
            if (b_ready !== e_rdy[k]) begin n_fail++; $display("FAIL b2b_ready cyc %0d: got %b want %b", k, b_ready, e_rdy[k]); end
            n_tests++;
            if (b_pipe_out !== e_pip[k]) begin n_fail++; $display("FAIL b2b_pipe cyc %0d: got %h want %h", k, b_pipe_out, e_pip[k]); end
            n_tests++;
            if ({b_rsp_valid, b_rsp_last, b_rsp_id, b_rsp_data} !== e_rsp[k]) begin
                n_fail++; $display("FAIL b2b_rsp cyc %0d: got %h want %h", k, {b_rsp_valid, b_rsp_last, b_rsp_id, b_rsp_data}, e_rsp[k]);
            end
            tick();
        end
    endtask

    task automatic test_mid_frame_reset();
        logic        rs   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [1:0]  vld  [6] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
        logic [1:0]  e_rdy[6] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
        logic [7:0]  e_pip[6] = '{8'hE0, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h00};
        logic [10:0] e_rsp[6] = '{11'h000, 11'h000, 11'h000, 11'h000, 11'h7F0, 11'h000};
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            rst     = rs[k];
            a_valid = vld[k];
            a_last  = 2'b10;
            a_data  = {8'hF0, (k == 0) ? 8'hE0 : 8'hE1};
            #1;
            n_tests++;
            if (a_ready !== e_rdy[k]) begin n_fail++; $display("FAIL mrst_ready cyc %0d: got %b want %b", k, a_ready, e_rdy[k]); end
            n_tests++;
            if (a_pipe_out !== e_pip[k]) begin n_fail++; $display("FAIL mrst_pipe cyc %0d: got %h want %h", k, a_pipe_out, e_pip[k]); end
            n_tests++;
            if ({a_rsp_valid, a_rsp_last, a_rsp_id, a_rsp_data} !== e_rsp[k]) begin
                n_fail++; $display("FAIL mrst_rsp cyc %0d: got %h want %h", k, {a_rsp_valid, a_rsp_last, a_rsp_id, a_rsp_data}, e_rsp[k]);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_depth();
        logic [1:0]  vld  [3] = '{2'b00, 2'b10, 2'b00};
        logic [1:0]  e_rdy[3] = '{2'b00, 2'b10, 2'b00};
        logic [10:0] e_rsp[3] = '{11'h000, 11'h75A, 11'h000};
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            c_valid = vld[k];
            c_last  = 2'b10;
            c_data  = 16'h5A33;
            #1;
            n_tests++;
            if (c_ready !== e_rdy[k]) begin n_fail++; $display("FAIL d0_ready cyc %0d: got %b want %b", k, c_ready, e_rdy[k]); end
            n_tests++;
            if ({c_rsp_valid, c_rsp_last, c_rsp_id, c_rsp_data} !== e_rsp[k]) begin
                n_fail++; $display("FAIL d0_rsp cyc %0d: got %h want %h", k, {c_rsp_valid, c_rsp_last, c_rsp_id, c_rsp_data}, e_rsp[k]);
            end
            tick();
        end
    endtask

    initial begin
        clear_inputs();
        tick();
        test_reset();
        test_single_frame();
        test_alternate();
        test_stall_lock();
        test_back_to_back();
        test_mid_frame_reset();
        test_zero_depth();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
